// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dmem_pkg;

    // Responder state encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Width of the wait-state counter (supports 0..15 wait states).
    localparam int WAIT_CNT_W = 4;

    // Big-endian byte lanes: lane 0 is the byte at the word address and
    // carries the most significant bits of the word.
    localparam int NUM_LANES = 4;
    localparam int LANE0_LSB = 24;
    localparam int LANE1_LSB = 16;
    localparam int LANE2_LSB = 8;
    localparam int LANE3_LSB = 0;

    // Bit position of the least significant bit of a given lane.
    function automatic int lane_lsb(input int lane);
        case (lane)
            0:       return LANE0_LSB;
            1:       return LANE1_LSB;
            2:       return LANE2_LSB;
            default: return LANE3_LSB;
        endcase
    endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// Byte-addressed storage with a 4-byte big-endian write port and combinational 4-byte read.
// Latency: write takes effect at the clock edge; read is combinational from the array.
// Backpressure: none; the array accepts a write every cycle wr_en is high.
// Ports: clk, rst_n (async clear of every byte), wr_en/wr_idx/wr_word (word write
// starting at byte wr_idx), rd_idx/rd_word (word read starting at byte rd_idx).
module dmem_byte_array
    import dmem_pkg::*;
#(
    parameter int MEM_BYTES = 32,
    parameter int IDX_W     = $clog2(MEM_BYTES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [31:0]      wr_word,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_word
);

    logic [7:0] mem [MEM_BYTES];

    // Index arithmetic is IDX_W wide, so lanes past the top of the array wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_BYTES; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (wr_en) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                mem[wr_idx + IDX_W'(l)] <= wr_word[lane_lsb(l) +: 8];
            end
        end
    end

    always_comb begin
        rd_word = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            rd_word[lane_lsb(l) +: 8] = mem[rd_idx + IDX_W'(l)];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Target-side data-memory responder: one word load/store at a time, big-endian byte array.
// Latency: response valid WAIT_CYCLES+1 edges after the accepting edge.
// Backpressure: response held stable until rsp_ready; req_ready only while idle.
// Ports: clk, rst_n (async, active low); request channel req_valid/req_ready/req_write/
// req_addr/req_wdata; response channel rsp_valid/rsp_ready/rsp_rdata/rsp_err.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int MEM_BYTES   = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int                    IDX_W     = $clog2(MEM_BYTES);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_CYCLES);

    state_t                state, state_nxt;
    logic [WAIT_CNT_W-1:0] cnt, cnt_nxt;

    logic             hold_write;
    logic [IDX_W-1:0] hold_idx;
    logic [31:0]      hold_wdata;
    logic             hold_mis;

    logic             accept;
    logic             enter_resp;
    logic             rsp_done;
    logic             mem_wr_en;
    logic [31:0]      mem_rd_word;

    // Upper address bits only alias onto the array.
    logic             unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:IDX_W];

    assign req_ready  = (state == ST_IDLE);
    assign rsp_valid  = (state == ST_RESP);
    assign accept     = (state == ST_IDLE) && req_valid;
    assign rsp_done   = (state == ST_RESP) && rsp_ready;
    // WAIT always spends one capture cycle before counting, so the counter
    // reaching WAIT_CYCLES marks the edge that enters RESP. This gives the
    // WAIT_CYCLES+1 latency, including the zero-wait build.
    assign enter_resp = (state == ST_WAIT) && (cnt == WAIT_LAST);
    assign mem_wr_en  = enter_resp && hold_write && !hold_mis;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = '0;
                end
            end
            ST_WAIT: begin
                if (cnt == WAIT_LAST) begin
                    state_nxt = ST_RESP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + WAIT_CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Request capture; inputs are free to change once the request is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_write <= 1'b0;
            hold_idx   <= '0;
            hold_wdata <= '0;
            hold_mis   <= 1'b0;
        end else if (accept) begin
            hold_write <= req_write;
            hold_idx   <= req_addr[IDX_W-1:0];
            hold_wdata <= req_wdata;
            hold_mis   <= (req_addr[1:0] != 2'b00);
        end
    end

    // Response registers: loaded on the edge entering RESP, cleared on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (enter_resp) begin
            rsp_rdata <= (!hold_write && !hold_mis) ? mem_rd_word : 32'h0;
            rsp_err   <= hold_mis;
        end else if (rsp_done) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end
    end

    dmem_byte_array #(
        .MEM_BYTES (MEM_BYTES),
        .IDX_W     (IDX_W)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (mem_wr_en),
        .wr_idx  (hold_idx),
        .wr_word (hold_wdata),
        .rd_idx  (hold_idx),
        .rd_word (mem_rd_word)
    );

endmodule
